// File: rtl/decoder2_4_behav_always.sv
// ---------------------------------------------------------------------------
// decoder2_4_behav_always
//
// Registered 2-to-4 one-hot decoder with per-output saturating hit counters.
//
// Ports:
//   clk          in   single clock, all state updates on its rising edge
//   rst          in   asynchronous, active-high reset of all state
//   enable       in   1 = decode {A,B}, 0 = all Y outputs inactive
//   A, B         in   select bits, A is the MSB of the decode index
//   clr          in   synchronous clear of all four hit counters
//   Y0..Y3       out  registered one-hot decode of {A,B}
//   active       out  registered copy of enable (OR of Y0..Y3)
//   code_q       out  last {A,B} seen while enable=1
//   cnt0..cnt3   out  saturating hit counters, one per Y output
// ---------------------------------------------------------------------------
module decoder2_4_behav_always #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             A,
  input  logic             B,
  input  logic             clr,
  output logic             Y0,
  output logic             Y1,
  output logic             Y2,
  output logic             Y3,
  output logic             active,
  output logic [1:0]       code_q,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]                  sel;
  logic [3:0]                  y_d, y_q;
  logic                        active_d, active_q;
  logic [1:0]                  code_d;
  logic [3:0][CNT_W-1:0]       cnt_d, cnt_q;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 1'b1;
    end
  endfunction

  assign sel = {A, B};

  always_comb begin
    y_d      = 4'b0000;
    active_d = enable;
    code_d   = code_q;
    cnt_d    = cnt_q;

    if (enable) begin
      y_d    = 4'b0001 << sel;
      code_d = sel;
    end

    // Clear wins over a same-edge increment; the decode itself is unaffected.
    for (int i = 0; i < 4; i++) begin
      if (clr) begin
        cnt_d[i] = '0;
      end else if (y_d[i]) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= 4'b0000;
      active_q <= 1'b0;
      code_q   <= 2'b00;
      cnt_q    <= '0;
    end else begin
      y_q      <= y_d;
      active_q <= active_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Y0     = y_q[0];
  assign Y1     = y_q[1];
  assign Y2     = y_q[2];
  assign Y3     = y_q[3];
  assign active = active_q;
  assign cnt0   = cnt_q[0];
  assign cnt1   = cnt_q[1];
  assign cnt2   = cnt_q[2];
  assign cnt3   = cnt_q[3];

endmodule

// File: tb/tb_decoder2_4_behav_always.sv
// ---------------------------------------------------------------------------
// tb_decoder2_4_behav_always
//
// Self-checking bench for decoder2_4_behav_always: hand-written vector table,
// saturation / clear / asynchronous reset sequences, and randomized traffic
// compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_decoder2_4_behav_always;

  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic             A = 1'b0;
  logic             B = 1'b0;
  logic             clr = 1'b0;
  logic             Y0, Y1, Y2, Y3, active;
  logic [1:0]       code_q;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  int tests  = 0;
  int failed = 0;

  // Behavioural model state
  int m_y, m_act, m_code;
  int m_cnt[4];

  typedef struct {
    logic en, a, b, c;
    int   y, act, code, c0, c1, c2, c3;
  } vec_t;

  vec_t vecs[8];

  decoder2_4_behav_always #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .A(A), .B(B), .clr(clr),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .active(active), .code_q(code_q),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int y_vec();
    return int'({Y3, Y2, Y1, Y0});
  endfunction

  function automatic int dut_cnt(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic model_reset();
    m_y = 0; m_act = 0; m_code = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input logic en, input logic a, input logic b, input logic c);
    int idx;
    idx   = (a ? 2 : 0) + (b ? 1 : 0);
    m_y   = en ? (1 << idx) : 0;
    m_act = en ? 1 : 0;
    if (en) m_code = idx;
    if (c) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (en && m_cnt[idx] < MAXC) begin
      m_cnt[idx] = m_cnt[idx] + 1;
    end
  endtask

  task automatic check_model(input string tag);
    int ones;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += (y_vec() >> i) & 1;
    tests++;
    if (ones > 1) begin
      failed++;
      $display("FAIL %s onehot: got Y=%b with %0d bits set, required at most 1", tag, y_vec(), ones);
    end
    chk({tag, " Y"}, y_vec(), m_y);
    chk({tag, " active"}, int'(active), m_act);
    chk({tag, " code_q"}, int'(code_q), m_code);
    for (int i = 0; i < 4; i++) chk($sformatf("%s cnt%0d", tag, i), dut_cnt(i), m_cnt[i]);
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass,
  // return at the next falling edge and compare against the model.
  task automatic apply(input logic en, input logic a, input logic b, input logic c,
                       input string tag);
    enable = en; A = a; B = b; clr = c;
    @(posedge clk);
    model_edge(en, a, b, c);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    //            en  a   b   c     y  act code c0 c1 c2 c3
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0, 1, 1, 0, 1, 0, 0, 0};
    vecs[1] = '{1'b1,1'b0,1'b1,1'b0, 2, 1, 1, 1, 1, 0, 0};
    vecs[2] = '{1'b1,1'b1,1'b0,1'b0, 4, 1, 2, 1, 1, 1, 0};
    vecs[3] = '{1'b1,1'b1,1'b1,1'b0, 8, 1, 3, 1, 1, 1, 1};
    vecs[4] = '{1'b0,1'b1,1'b0,1'b0, 0, 0, 3, 1, 1, 1, 1};
    vecs[5] = '{1'b1,1'b1,1'b1,1'b0, 8, 1, 3, 1, 1, 1, 2};
    vecs[6] = '{1'b1,1'b0,1'b1,1'b1, 2, 1, 1, 0, 0, 0, 0};
    vecs[7] = '{1'b1,1'b0,1'b0,1'b0, 1, 1, 0, 1, 0, 0, 0};

    model_reset();

    // Reset takes effect before the first clock edge
    #2 rst = 1'b1;
    #1;
    chk("reset Y", y_vec(), 0);
    chk("reset active", int'(active), 0);
    chk("reset code_q", int'(code_q), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("reset cnt%0d", i), dut_cnt(i), 0);

    @(negedge clk);
    rst = 1'b0;

    // Vector table: sweep, disable, clear priority
    for (int k = 0; k < 8; k++) begin
      apply(vecs[k].en, vecs[k].a, vecs[k].b, vecs[k].c, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d tbl Y", k), y_vec(), vecs[k].y);
      chk($sformatf("vec%0d tbl active", k), int'(active), vecs[k].act);
      chk($sformatf("vec%0d tbl code_q", k), int'(code_q), vecs[k].code);
      chk($sformatf("vec%0d tbl cnt0", k), int'(cnt0), vecs[k].c0);
      chk($sformatf("vec%0d tbl cnt1", k), int'(cnt1), vecs[k].c1);
      chk($sformatf("vec%0d tbl cnt2", k), int'(cnt2), vecs[k].c2);
      chk($sformatf("vec%0d tbl cnt3", k), int'(cnt3), vecs[k].c3);
    end

    // Saturation: 300 hits on Y3
    for (int k = 0; k < 300; k++) apply(1'b1, 1'b1, 1'b1, 1'b0, "sat");
    chk("sat cnt3 final", int'(cnt3), 255);
    chk("sat cnt0 unchanged", int'(cnt0), 1);
    chk("sat cnt1 unchanged", int'(cnt1), 0);
    chk("sat cnt2 unchanged", int'(cnt2), 0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, "sat hold");
    chk("sat cnt3 hold", int'(cnt3), 255);

    // Build Y2=1, cnt2=5, then assert reset between edges
    apply(1'b0, 1'b0, 1'b0, 1'b1, "pre clr");
    for (int k = 0; k < 5; k++) apply(1'b1, 1'b1, 1'b0, 1'b0, "pre async");
    chk("pre async Y2", int'(Y2), 1);
    chk("pre async cnt2", int'(cnt2), 5);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async Y", y_vec(), 0);
    chk("async active", int'(active), 0);
    chk("async cnt2", int'(cnt2), 0);
    chk("async code_q", int'(code_q), 0);
    // State holds while reset is held, whatever the inputs do
    enable = 1'b1; A = 1'b1; B = 1'b1; clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_model("rst held");
    rst = 1'b0;
    apply(1'b1, 1'b0, 1'b1, 1'b0, "post rst");
    chk("post rst Y1", int'(Y1), 1);
    chk("post rst cnt1", int'(cnt1), 1);

    // Randomized traffic against the model
    for (int k = 0; k < 1000; k++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0), $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
